// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - opcodes, FSM/ALU enums and ALU helpers shared by npc_mc
package npc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_WB, ST_HALT} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt selects SUB/SRA on the funct3 codes that share an encoding
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return a + b;
    endcase
  endfunction

endpackage

// File: rtl/npc_mc_regfile.sv
// rtl/npc_mc_regfile.sv - NREGS x 32 register file, 2 async reads, 1 sync write, x0 hardwired
module npc_mc_regfile #(
  parameter int NREGS = 32
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);
  localparam int AW = $clog2(NREGS);

  logic [31:0] regs_q [NREGS];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) regs_q[waddr_i[AW-1:0]] <= wdata_i;
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : regs_q[raddr_a_i[AW-1:0]];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : regs_q[raddr_b_i[AW-1:0]];

endmodule

// File: rtl/npc_mc.sv
// rtl/npc_mc.sv - multi-cycle RV32I/RV32E core; LW/SW and dmem port under NPC_MC_LSU_EN
module npc_mc
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef NPC_MC_LSU_EN
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
`endif
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_wdata,
  output logic        halt,
  output logic        halt_illegal
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, res_q, res_d, npc_q, npc_d;
  logic [4:0]  wrd_q, wrd_d;
  logic        ill_q, ill_d;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] rs1_data, rs2_data, imm_i, imm_u, imm_j;

  assign opc   = ir_q[6:0];
  assign rd    = ir_q[11:7];
  assign f3    = ir_q[14:12];
  assign rs1   = ir_q[19:15];
  assign rs2   = ir_q[24:20];
  assign f7    = ir_q[31:25];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  npc_mc_regfile #(.NREGS(NREGS)) u_rf (
    .clk_i     (clk),
    .we_i      ((state_q == ST_WB) && (wrd_q != 5'd0)),
    .waddr_i   (wrd_q),
    .wdata_i   (res_q),
    .raddr_a_i (rs1),
    .rdata_a_o (rs1_data),
    .raddr_b_i (rs2),
    .rdata_b_o (rs2_data)
  );

  logic        legal, use_rs1, use_rs2, use_rd, is_mem;
  alu_op_e     alu_op;
  logic [31:0] opa, opb, next_pc;

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    is_mem  = 1'b0;
    alu_op  = ALU_ADD;
    opa     = rs1_data;
    opb     = imm_i;
    next_pc = pc_q + 32'd4;
    case (opc)
      OP_LUI:   begin legal = 1'b1; use_rd = 1'b1; opa = 32'd0; opb = imm_u; end
      OP_AUIPC: begin legal = 1'b1; use_rd = 1'b1; opa = pc_q;  opb = imm_u; end
      OP_JAL: begin
        legal = 1'b1; use_rd = 1'b1; opa = pc_q; opb = 32'd4;
        next_pc = pc_q + imm_j;
      end
      OP_JALR: begin
        legal = (f3 == 3'd0); use_rd = 1'b1; use_rs1 = 1'b1; opa = pc_q; opb = 32'd4;
        next_pc = (rs1_data + imm_i) & ~32'd1;
      end
      OP_OPIMM: begin
        legal   = (f3 == 3'd1) ? (f7 == 7'h00) :
                  (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        use_rd  = 1'b1; use_rs1 = 1'b1;
        alu_op  = f3_to_op(f3, (f3 == 3'd5) && f7[5]);
      end
      OP_OP: begin
        legal   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        use_rd  = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        opb     = rs2_data;
        alu_op  = f3_to_op(f3, f7[5]);
      end
      OP_SYSTEM: legal = (ir_q == EBREAK);
`ifdef NPC_MC_LSU_EN
      OP_LOAD:  begin legal = (f3 == 3'd2); use_rd = 1'b1; use_rs1 = 1'b1; is_mem = 1'b1; end
      OP_STORE: begin
        legal = (f3 == 3'd2); use_rs1 = 1'b1; use_rs2 = 1'b1; is_mem = 1'b1;
        opb   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end
`endif
      default: ;
    endcase
    // RV32E has no x16..x31; only fields the format actually uses are checked
    if (NREGS == 16 && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4])))
      legal = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    npc_d   = npc_q;
    wrd_d   = wrd_q;
    ill_d   = ill_q;
    case (state_q)
      ST_FETCH: if (imem_rvalid) begin ir_d = imem_rdata; state_d = ST_EXEC; end
      ST_EXEC: begin
        if (!legal) begin
          ill_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          res_d   = alu(alu_op, opa, opb);
          npc_d   = next_pc;
          wrd_d   = use_rd ? rd : 5'd0;
          state_d = is_mem ? ST_MEM : ST_WB;
        end
      end
`ifdef NPC_MC_LSU_EN
      ST_MEM: if (dmem_rvalid) begin
        if (opc == OP_LOAD) res_d = dmem_rdata;
        state_d = ST_WB;
      end
`else
      ST_MEM: state_d = ST_WB;
`endif
      ST_WB: begin
        pc_d    = npc_q;
        state_d = (ir_q == EBREAK) ? ST_HALT : ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      res_q   <= '0;
      npc_q   <= '0;
      wrd_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
      npc_q   <= npc_d;
      wrd_q   <= wrd_d;
      ill_q   <= ill_d;
    end
  end

  // request is masked by rst_n so it stays low for the whole reset pulse
  assign imem_req     = rst_n && (state_q == ST_FETCH);
  assign imem_addr    = pc_q;
  assign commit_valid = (state_q == ST_WB);
  assign commit_pc    = commit_valid ? pc_q : 32'd0;
  assign commit_inst  = commit_valid ? ir_q : 32'd0;
  assign commit_rd    = commit_valid ? wrd_q : 5'd0;
  assign commit_wdata = (commit_valid && wrd_q != 5'd0) ? res_q : 32'd0;
  assign halt         = (state_q == ST_HALT);
  assign halt_illegal = ill_q;

`ifdef NPC_MC_LSU_EN
  assign dmem_req   = (state_q == ST_MEM);
  assign dmem_we    = (opc == OP_STORE);
  assign dmem_addr  = res_q;
  assign dmem_wdata = rs2_data;
`endif

endmodule

// File: tb/tb_npc_mc.sv
// tb/tb_npc_mc.sv - directed bench for npc_mc (RV32I instance plus an RV32E instance)
module tb_npc_mc;
  logic        clk, rst_n, rv_en;
  logic        imem_req, commit_valid, halt, halt_illegal;
  logic [31:0] imem_addr, imem_rdata, commit_pc, commit_inst, commit_wdata;
  logic [4:0]  commit_rd;
  logic [31:0] rom [128];
  logic        e_req, e_cv, e_halt, e_ill;
  logic [31:0] e_addr, e_word, e_cpc, e_cinst, e_cwd;
  logic [4:0]  e_crd;
  int          total = 0, bad = 0;

  assign imem_rdata = rom[imem_addr[8:2]];

`ifdef NPC_MC_LSU_EN
  logic        dmem_req, dmem_we, dmem_rvalid, e_dreq, e_dwe;
  logic [31:0] dmem_addr, dmem_wdata, dm_word, e_daddr, e_dwdata;
  assign dmem_rvalid = dmem_req;
  always @(posedge clk)
    if (dmem_req && dmem_we && dmem_addr == 32'h8000_0100) dm_word <= dmem_wdata;
`endif

  npc_mc u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(rv_en), .imem_rdata(imem_rdata),
`ifdef NPC_MC_LSU_EN
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dm_word),
`endif
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata),
    .halt(halt), .halt_illegal(halt_illegal)
  );

  npc_mc #(.NREGS(16)) u_dut_e (
    .clk(clk), .rst_n(rst_n),
    .imem_req(e_req), .imem_addr(e_addr), .imem_rvalid(1'b1), .imem_rdata(e_word),
`ifdef NPC_MC_LSU_EN
    .dmem_req(e_dreq), .dmem_we(e_dwe), .dmem_addr(e_daddr), .dmem_wdata(e_dwdata),
    .dmem_rvalid(1'b0), .dmem_rdata(32'h0),
`endif
    .commit_valid(e_cv), .commit_pc(e_cpc), .commit_inst(e_cinst),
    .commit_rd(e_crd), .commit_wdata(e_cwd),
    .halt(e_halt), .halt_illegal(e_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // waits for the next commit (bounded) and checks latency in cycles plus all commit fields
  task automatic run(input string tag, input int lat, input logic [31:0] pc,
                     input logic [31:0] inst, input logic [4:0] rd, input logic [31:0] wd);
    int n = 0;
    do begin @(negedge clk); n++; end while (commit_valid !== 1'b1 && n < 20);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_pc"}, commit_pc, pc);
    chk({tag, "_inst"}, commit_inst, inst);
    chk({tag, "_rd"}, {27'd0, commit_rd}, {27'd0, rd});
    chk({tag, "_wdata"}, commit_wdata, wd);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 32'hFFFF_FFFF;
    rom[0]  = 32'h00A0_0093;  // addi x1,x0,10
    rom[1]  = 32'hFFD0_8113;  // addi x2,x1,-3
    rom[2]  = 32'h4011_01B3;  // sub  x3,x2,x1
    rom[3]  = 32'h4011_D213;  // srai x4,x3,1
    rom[4]  = 32'h0030_B2B3;  // sltu x5,x1,x3
    rom[5]  = 32'h0030_A333;  // slt  x6,x1,x3
    rom[6]  = 32'h8000_03B7;  // lui  x7,0x80000
    rom[7]  = 32'h0000_1417;  // auipc x8,1
    rom[8]  = 32'h0080_00EF;  // jal  x1,+8
    rom[10] = 32'h1013_8113;  // addi x2,x7,0x101
    rom[11] = 32'h0011_0067;  // jalr x0,1(x2)
    rom[64] = 32'h0010_0073;  // ebreak at 0x8000_0100/0x102
    rst_n  = 1'b0;
    rv_en  = 1'b1;
    e_word = 32'h0010_0793;   // addi x15,x0,1: legal on RV32E
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h8000_0000);
    chk("rst_cv", {31'd0, commit_valid}, 32'd0);
    chk("rst_cpc", commit_pc, 32'd0);
    chk("rst_cinst", commit_inst, 32'd0);
    chk("rst_crd", {27'd0, commit_rd}, 32'd0);
    chk("rst_cwd", commit_wdata, 32'd0);
    chk("rst_halt", {30'd0, halt, halt_illegal}, 32'd0);

    rst_n = 1'b1;
    #1 chk("rel_req", {31'd0, imem_req}, 32'd1);
    run("addi", 2, 32'h8000_0000, 32'h00A0_0093, 5'd1, 32'd10);
    chk("e_cv", {31'd0, e_cv}, 32'd1);
    chk("e_x15", {27'd0, e_crd}, 32'd15);
    chk("e_x15_wd", e_cwd, 32'd1);
    e_word = 32'h0010_0813;   // addi x16,x0,1: illegal on RV32E

    rv_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, 32'h8000_0004);
    end
    rv_en = 1'b1;
    run("addi_neg", 2, 32'h8000_0004, 32'hFFD0_8113, 5'd2, 32'd7);
    run("sub", 3, 32'h8000_0008, 32'h4011_01B3, 5'd3, 32'hFFFF_FFFD);
    run("srai", 3, 32'h8000_000C, 32'h4011_D213, 5'd4, 32'hFFFF_FFFE);
    run("sltu", 3, 32'h8000_0010, 32'h0030_B2B3, 5'd5, 32'd1);
    run("slt", 3, 32'h8000_0014, 32'h0030_A333, 5'd6, 32'd0);
    run("lui", 3, 32'h8000_0018, 32'h8000_03B7, 5'd7, 32'h8000_0000);
    run("auipc", 3, 32'h8000_001C, 32'h0000_1417, 5'd8, 32'h8000_101C);
    run("jal", 3, 32'h8000_0020, 32'h0080_00EF, 5'd1, 32'h8000_0024);
    run("addi_x2", 3, 32'h8000_0028, 32'h1013_8113, 5'd2, 32'h8000_0101);
    run("jalr", 3, 32'h8000_002C, 32'h0011_0067, 5'd0, 32'd0);
    run("ebreak", 3, 32'h8000_0102, 32'h0010_0073, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("eb_halt", {30'd0, halt, halt_illegal}, 32'd2);
      chk("eb_req", {31'd0, imem_req}, 32'd0);
      chk("eb_cv", {31'd0, commit_valid}, 32'd0);
    end
    chk("e_halt_ill", {30'd0, e_halt, e_ill}, 32'd3);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run("r_addi", 2, 32'h8000_0000, 32'h00A0_0093, 5'd1, 32'd10);
    rv_en = 1'b0;
    @(negedge clk);
    chk("r_stall_addr", imem_addr, 32'h8000_0004);
    rst_n = 1'b0;
    #1 chk("r_req_low", {31'd0, imem_req}, 32'd0);
    chk("r_pc", imem_addr, 32'h8000_0000);
    chk("r_cv", {31'd0, commit_valid}, 32'd0);
    rom[0] = 32'hFFFF_FFFF;
    @(negedge clk); rv_en = 1'b1;
    @(negedge clk); rv_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("r_fetch_req", {31'd0, imem_req}, 32'd1);
      chk("r_fetch_addr", imem_addr, 32'h8000_0000);
      chk("r_fetch_cpc", commit_pc, 32'd0);
      chk("r_fetch_cwd", commit_wdata, 32'd0);
    end
    rv_en = 1'b1;
    @(negedge clk);
    chk("ill_exec", {30'd0, halt, commit_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ill_halt", {30'd0, halt, halt_illegal}, 32'd3);
      chk("ill_cv", {31'd0, commit_valid}, 32'd0);
      chk("ill_req", {31'd0, imem_req}, 32'd0);
    end

`ifdef NPC_MC_LSU_EN
    rst_n  = 1'b0;
    rom[0] = 32'h1234_50B7;  // lui  x1,0x12345
    rom[1] = 32'h6780_8093;  // addi x1,x1,0x678
    rom[2] = 32'h8000_0137;  // lui  x2,0x80000
    rom[3] = 32'h1011_2023;  // sw   x1,0x100(x2)
    rom[4] = 32'h1001_2183;  // lw   x3,0x100(x2)
    rom[5] = 32'h0010_0073;  // ebreak
    @(negedge clk);
    rst_n = 1'b1;
    run("l_lui", 2, 32'h8000_0000, 32'h1234_50B7, 5'd1, 32'h1234_5000);
    run("l_addi", 3, 32'h8000_0004, 32'h6780_8093, 5'd1, 32'h1234_5678);
    run("l_lui2", 3, 32'h8000_0008, 32'h8000_0137, 5'd2, 32'h8000_0000);
    run("l_sw", 4, 32'h8000_000C, 32'h1011_2023, 5'd0, 32'd0);
    run("l_lw", 4, 32'h8000_0010, 32'h1001_2183, 5'd3, 32'h1234_5678);
    run("l_ebreak", 3, 32'h8000_0014, 32'h0010_0073, 5'd0, 32'd0);
    @(negedge clk);
    chk("l_halt", {30'd0, halt, halt_illegal}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npc_mc.md
# npc_mc

Multi-cycle, parametrised RV32I/RV32E processor core that replaces the single-cycle NPC top. It owns its own PC, register file, decoder and ALU. It fetches instructions over a request/response instruction port instead of receiving them from the simulator. It exposes a per-instruction commit port for difftest and a halt indication for EBREAK and illegal instructions.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- NREGS, 32, architectural register count; legal values are 32 (RV32I) and 16 (RV32E).
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_rvalid.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_rvalid  in  1  fetch data valid; may be high in the same cycle as imem_req, or any later cycle.
- imem_rdata  in  32  instruction word; sampled only when imem_rvalid=1.
- dmem_req, dmem_we, dmem_addr[31:0], dmem_wdata[31:0], dmem_rvalid, dmem_rdata[31:0]: data port. Present only with NPC_MC_LSU_EN.
- commit_valid  out  1  one-cycle pulse per retired instruction.
- commit_pc  out  32  PC of the retired instruction.
- commit_inst  out  32  instruction word of the retired instruction.
- commit_rd  out  5  destination register index; 0 if there is no write.
- commit_wdata  out  32  value written to commit_rd; 0 if there is no write.
- halt  out  1  sticky; core stopped.
- halt_illegal  out  1  sticky; qualifies halt as an illegal-instruction stop (0 = EBREAK).

## Operation
- FSM states: FETCH, EXEC, MEM (LSU build only), WB, HALT.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_rvalid: latch ir<=imem_rdata and go to EXEC.
- EXEC: decode ir and compute the ALU result and next_pc.
  - Load/store -> MEM.
  - Illegal instruction -> HALT with halt_illegal=1.
  - Otherwise -> WB.
- MEM: dmem_req=1, with dmem_addr, dmem_we and dmem_wdata held stable.
  - On dmem_rvalid -> WB; a load latches dmem_rdata.
- WB:
  - Write rd if rd!=0.
  - pc<=next_pc.
  - commit_valid=1 with all commit_* fields.
  - Next state: EBREAK -> HALT, else FETCH.
- HALT: absorbing; no requests and no register writes. Exit only through reset.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
  - EBREAK.
  - LW/SW with the LSU build only.
- Every other encoding is illegal.
- With NREGS=16, an rs1, rs2 or rd index with bit 4 set is illegal.
- Arithmetic:
  - 32-bit wrap-around.
  - Shift amount is the low 5 bits.
  - Immediates are sign-extended from bit 31 of ir.
  - JALR target: (rs1+imm) & ~1.
  - JAL/JALR write pc+4.
- x0 reads 0 and writes to it are discarded. The register file is not reset, except that x0 reads 0.
- Next PC: pc+4 unless the instruction is JAL or JALR. Misaligned targets are not checked.

## Timing
- Reset values:
  - pc=RESET_PC, state=FETCH.
  - ir=0.
  - All commit_* outputs=0.
  - halt=0, halt_illegal=0.
  - imem_req=0 while rst_n=0; imem_req rises in the first cycle after deassertion.
- ALU or jump instruction with zero-wait fetch: 3 cycles (FETCH, EXEC, WB).
- Each imem wait cycle adds 1 cycle.
- Load/store: 4 cycles plus dmem wait cycles.
- Halt timing:
  - EBREAK: commit_valid pulses in WB, and halt rises on the next edge.
  - Illegal instruction: halt rises on the edge leaving EXEC, with no commit.
- Reset mid-operation: asynchronously returns to FETCH at RESET_PC.
  - Any outstanding response is ignored; the memory model must tolerate a dropped request.
- imem_rvalid is ignored outside FETCH. dmem_rvalid is ignored outside MEM.

## Configuration
- NPC_MC_LSU_EN defined:
  - The dmem port, the MEM state, and LW/SW decode are compiled in.
  - commit_wdata for a store is 0 and commit_rd=0.
- NPC_MC_LSU_EN undefined:
  - The dmem ports are absent.
  - LW/SW decode as illegal.

## Structure
- Package npc_pkg holds:
  - Opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OPIMM, OP_OP, OP_LOAD, OP_STORE, OP_SYSTEM.
  - FSM state enum.
  - ALU-op enum.
  - EBREAK encoding 32'h0010_0073.
- Sub-module npc_mc_regfile, parametrised by NREGS:
  - 2 combinational read ports and 1 synchronous write port.
  - Hardwired x0.

## Test plan
- Fetch ADDI x1,x0,10 (32'h00A0_0093) at 0x8000_0000 with zero-wait -> commit_valid in cycle 3 after reset release; commit_rd=1, commit_wdata=10; next imem_addr=0x8000_0004.
- Assert imem_rvalid 3 cycles late -> imem_req and imem_addr stay stable for 4 cycles; commit occurs 3 cycles later than in the zero-wait case.
- Execute JAL x1,+8 at 0x8000_0000 -> commit_wdata=0x8000_0004; next fetch at 0x8000_0008. Execute JALR x0,1(x2) with x2=0x8000_0101 -> next fetch at 0x8000_0102.
- Fetch EBREAK -> one commit, then halt=1 and halt_illegal=0; imem_req stays 0 thereafter. Fetch 32'hFFFF_FFFF -> halt=1 and halt_illegal=1, with no commit.
- Pull rst_n low during a stalled FETCH, then release it -> pc=RESET_PC and commit_* outputs are 0; a late imem_rvalid pulse that arrives during reset is ignored.
- Run with NREGS=16: ADDI x16,x0,1 -> halt_illegal=1. With NPC_MC_LSU_EN: SW of 0x1234_5678 to 0x8000_0100, then LW x3 from 0x8000_0100 -> commit_wdata=0x1234_5678.
